alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 4-mode ALU. It keeps the same mode encoding: add, multiply, decrement A, pass B.
- Operands are accepted with a start/busy/done handshake.
- Multiply is an iterative shift-add unit taking WIDTH cycles; all other modes complete in one cycle.
- The result is registered and held until the next completion.

Parameters:
WIDTH, 8, operand width in bits; result width is 2*WIDTH; legal range 2..32.

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst  input  1  asynchronous, active-high reset
i_start  input  1  request; sampled on a rising edge while idle
i_A  input  WIDTH  operand A, unsigned
i_B  input  WIDTH  operand B, unsigned
i_mode  input  2  00 A+B, 01 A*B, 10 A-1, 11 B
o_busy  output  1  high while a multiply is in progress
o_done  output  1  one-cycle pulse; o_out is valid and updated
o_out  output  2*WIDTH  registered result

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_busy=0, o_done=0, o_out=0, internal accumulator/counter=0. Reset mid-multiply aborts the operation; no o_done is produced afterwards.
- States: IDLE, MUL.
- IDLE with i_start=1 at edge k: i_A, i_B and i_mode are captured at that edge; later input changes are ignored.
  - Modes 00/10/11: o_out is written at edge k and o_done=1 for the cycle after edge k. State stays IDLE.
  - Mode 01: captures multiplicand, multiplier and count=WIDTH, clears the accumulator, goes to MUL, o_busy=1.
- MUL, each edge: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Shift multiplicand left, multiplier right, count-1.
  - On the edge where the count reaches 0: write o_out=accumulator, o_done=1 for one cycle, state→IDLE, o_busy=0.
  - Multiply latency: o_done is high in the cycle after edge k+WIDTH. o_busy is high for exactly WIDTH cycles.
- i_start while in MUL is ignored; no queueing.
- i_start in the cycle where o_done=1 is accepted, since state is IDLE, giving back-to-back operation.
- o_done deasserts on the next edge unless a new single-cycle op completes on that edge.
- Arithmetic (all results are 2*WIDTH bits, unsigned):
  - 00: A+B zero-extended; carry lands in bit WIDTH.
  - 01: full product, never truncated.
  - 10: A-1 in 2*WIDTH-bit two's complement; A=0 gives all ones (e.g. 16'hFFFF for WIDTH=8).
  - 11: B zero-extended.
- o_out holds its last value between completions and is not cleared by i_start.
- Unknown/X on i_mode while idle with i_start=0 has no effect.

Optional Feature:
Macro ALU_SEQ_FLAGS_EN.
- Defined: adds output ports o_zero (1 bit) and o_ovf (1 bit), registered and updated on the same edge as o_out, both reset to 0.
  - o_zero=1 when the new result is 0.
  - o_ovf=1 when the upper WIDTH bits of the new result are nonzero (carry for add, wide product, borrow for 0-1).
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan (WIDTH=8):
1. A=10, B=5, mode 00, start pulse → o_done high one cycle later, o_out=15, o_busy never high. Mode 11 → 5. Mode 10 → 9.
2. A=10, B=5, mode 01 → o_busy high exactly 8 cycles, o_done in the cycle after edge k+8, o_out=50. A=255, B=255 → 65025.
3. A=0, mode 10 → o_out=65535. With ALU_SEQ_FLAGS_EN: o_ovf=1, o_zero=0. A=0, B=0, mode 00 → o_out=0, o_zero=1, o_ovf=0.
4. Start multiply 3*4, pulse i_start with mode 00 at busy cycle 3 → ignored; single o_done, o_out=12. Then start add 1+1 in the o_done cycle → o_out=2 one cycle later.
5. Start multiply 7*9, assert i_rst asynchronously between edges at busy cycle 4 → o_out=0, o_busy=0, o_done=0 immediately and no later o_done. After release, start 6*7 → 42 after 8 cycles.
6. Change i_A/i_B/i_mode every cycle during a 200*3 multiply → o_out=600, proving operands were captured at start.

Source files
------------

// File: rtl/alu_seq.sv
// Clocked 4-mode ALU (add, multiply, decrement A, pass B) with a start/busy/done handshake.
// Define ALU_SEQ_FLAGS_EN to add the registered o_zero/o_ovf result flags.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_A,
   input  logic [WIDTH-1:0]     i_B,
   input  logic [1:0]           i_mode,
   output logic                 o_busy,
   output logic                 o_done,
`ifdef ALU_SEQ_FLAGS_EN
   output logic                 o_zero,
   output logic                 o_ovf,
`endif
   output logic [2*WIDTH-1:0]   o_out
);

   localparam int unsigned RW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] MODE_ADD  = 2'b00;
   localparam logic [1:0] MODE_MUL  = 2'b01;
   localparam logic [1:0] MODE_DEC  = 2'b10;
   localparam logic [1:0] MODE_PASS = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [RW-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]      acc_q, acc_d;
   logic [RW-1:0]      out_q, out_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [RW-1:0]      acc_sum_c;

   // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
   assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Next-state and datapath
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      out_d    = out_q;
      done_d   = 1'b0;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               case (i_mode)
                  MODE_ADD: begin
                     out_d  = RW'(i_A) + RW'(i_B);
                     done_d = 1'b1;
                  end
                  MODE_MUL: begin
                     mcand_d  = RW'(i_A);
                     mplier_d = i_B;
                     cnt_d    = CNT_W'(WIDTH);
                     acc_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = ST_MUL;
                  end
                  MODE_DEC: begin
                     out_d  = RW'(i_A) - RW'(1);
                     done_d = 1'b1;
                  end
                  MODE_PASS: begin
                     out_d  = RW'(i_B);
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            acc_d    = acc_sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            // Final step: publish the sum including this edge's partial product
            if (cnt_q == CNT_W'(1)) begin
               out_d   = acc_sum_c;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign o_out  = out_q;
   assign o_done = done_q;
   assign o_busy = busy_q;

`ifdef ALU_SEQ_FLAGS_EN
   logic zero_q, zero_d;
   logic ovf_q, ovf_d;

   // Flags track the result being written this edge
   always_comb begin
      zero_d = zero_q;
      ovf_d  = ovf_q;
      if (done_d) begin
         zero_d = (out_d == '0);
         ovf_d  = |out_d[RW-1:WIDTH];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign o_zero = zero_q;
   assign o_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

   localparam int unsigned WIDTH = 8;

   logic               clk;
   logic               rst;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [1:0]         mode;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] out;
`ifdef ALU_SEQ_FLAGS_EN
   logic               zero;
   logic               ovf;
`endif

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_A     (a),
      .i_B     (b),
      .i_mode  (mode),
      .o_busy  (busy),
      .o_done  (done),
`ifdef ALU_SEQ_FLAGS_EN
      .o_zero  (zero),
      .o_ovf   (ovf),
`endif
      .o_out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Single-cycle op: start at edge k, return at the negedge in the cycle after k
   task automatic do_op(input logic [7:0] aa, input logic [7:0] bb, input logic [1:0] mm);
      @(negedge clk);
      a = aa; b = bb; mode = mm; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
   endtask

   // Multiply: reports busy cycles seen and the negedge index where done appeared (0 = timeout)
   task automatic run_mul(input logic [7:0] aa, input logic [7:0] bb, input bit scramble,
                          output int busy_n, output int lat);
      busy_n = 0;
      lat    = 0;
      @(negedge clk);
      a = aa; b = bb; mode = 2'b01; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin
            lat = i;
            break;
         end
         if (scramble) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            mode = 2'($urandom);
         end
      end
   endtask

   int bn, lat, dn;

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = '0;
      #2;
      check("rst_out", 32'(out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;

      // Single-cycle modes
      do_op(8'd10, 8'd5, 2'b00);
      check("add_done", 32'(done), 1);
      check("add_out", 32'(out), 15);
      check("add_busy", 32'(busy), 0);
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("hold_out", 32'(out), 15);
      do_op(8'd10, 8'd5, 2'b11);
      check("pass_out", 32'(out), 5);
      do_op(8'd10, 8'd5, 2'b10);
      check("dec_out", 32'(out), 9);

      // Multiply latency and width
      run_mul(8'd10, 8'd5, 1'b0, bn, lat);
      check("mul_busy_cyc", 32'(bn), 8);
      check("mul_latency", 32'(lat), 9);
      check("mul_out", 32'(out), 50);
      check("mul_busy_end", 32'(busy), 0);
      run_mul(8'd255, 8'd255, 1'b0, bn, lat);
      check("mul_max", 32'(out), 65025);
`ifdef ALU_SEQ_FLAGS_EN
      check("mul_max_ovf", 32'(ovf), 1);
`endif

      // Boundaries
      do_op(8'd0, 8'd0, 2'b10);
      check("dec_zero", 32'(out), 65535);
`ifdef ALU_SEQ_FLAGS_EN
      check("dec_zero_ovf", 32'(ovf), 1);
      check("dec_zero_z", 32'(zero), 0);
`endif
      do_op(8'd0, 8'd0, 2'b00);
      check("add_zero", 32'(out), 0);
`ifdef ALU_SEQ_FLAGS_EN
      check("add_zero_z", 32'(zero), 1);
      check("add_zero_ovf", 32'(ovf), 0);
`endif
      do_op(8'd255, 8'd1, 2'b00);
      check("add_carry", 32'(out), 256);

      // Start during multiply ignored, then back-to-back add in done cycle
      @(negedge clk);
      a = 8'd3; b = 8'd4; mode = 2'b01; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; dn = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
         if (i == 3) begin
            a = 8'd1; b = 8'd1; mode = 2'b00; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (i == 4) dn = 32'(done) + 32'(out == 16'd2);
      end
      check("ign_stray", 32'(dn), 0);
      check("ign_latency", 32'(lat), 9);
      check("ign_out", 32'(out), 12);
      a = 8'd1; b = 8'd1; mode = 2'b00; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("b2b_done", 32'(done), 1);
      check("b2b_out", 32'(out), 2);

      // Asynchronous reset mid-multiply
      @(negedge clk);
      a = 8'd7; b = 8'd9; mode = 2'b01; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 4; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_out", 32'(out), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("arst_no_done", 32'(dn), 0);
      run_mul(8'd6, 8'd7, 1'b0, bn, lat);
      check("post_rst_lat", 32'(lat), 9);
      check("post_rst_out", 32'(out), 42);

      // Operand capture: inputs scrambled while busy
      run_mul(8'd200, 8'd3, 1'b1, bn, lat);
      check("capture_lat", 32'(lat), 9);
      check("capture_out", 32'(out), 600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
